// File: rtl/writeback_cdb.sv
// Writeback end of the dispatch interface: registered CDB tag broadcast per unit and a
// completion queue that hands ROB indices to the ROB one per cycle.
module writeback_cdb #(
    parameter int PREG_W   = 7,
    parameter int ROB_W    = 5,
    parameter int CQ_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_wb_valid,
    input  logic [PREG_W-1:0] alu_wb_prd,
    input  logic              alu_wb_we,
    input  logic [ROB_W-1:0]  alu_wb_rob,
    output logic              alu_wb_ready,
    input  logic              br_wb_valid,
    input  logic [PREG_W-1:0] br_wb_prd,
    input  logic              br_wb_we,
    input  logic [ROB_W-1:0]  br_wb_rob,
    output logic              br_wb_ready,
    input  logic              lsu_wb_valid,
    input  logic [PREG_W-1:0] lsu_wb_prd,
    input  logic              lsu_wb_we,
    input  logic [ROB_W-1:0]  lsu_wb_rob,
    output logic              lsu_wb_ready,
    input  logic              mispredict,
    output logic [PREG_W-1:0] preg1_rdy,
    output logic              preg1_valid,
    output logic [PREG_W-1:0] preg2_rdy,
    output logic              preg2_valid,
    output logic [PREG_W-1:0] preg3_rdy,
    output logic              preg3_valid,
    output logic              complete_out,
    output logic [ROB_W-1:0]  rob_fu_tag
);
    localparam int PTR_W = $clog2(CQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Leave room for three enqueues in the same cycle, so readiness never depends on valids.
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(CQ_DEPTH - 3);

    logic [ROB_W-1:0]  cq_mem_q [CQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  slot_br, slot_lsu;
    logic [CNT_W-1:0]  count_q, count_d, n_enq;
    logic              ready, acc_alu, acc_br, acc_lsu, deq;
    logic              bc_alu, bc_br, bc_lsu;
    logic              complete_q;
    logic [ROB_W-1:0]  rob_tag_q;
    logic [PREG_W-1:0] preg1_q, preg2_q, preg3_q;
    logic              pv1_q, pv2_q, pv3_q;

    assign ready   = reset && (count_q <= CNT_LIMIT) && !mispredict;
    assign acc_alu = alu_wb_valid && ready;
    assign acc_br  = br_wb_valid && ready;
    assign acc_lsu = lsu_wb_valid && ready;
    assign bc_alu  = acc_alu && alu_wb_we && (alu_wb_prd != '0);
    assign bc_br   = acc_br && br_wb_we && (br_wb_prd != '0);
    assign bc_lsu  = acc_lsu && lsu_wb_we && (lsu_wb_prd != '0);

    always_comb begin
        n_enq    = CNT_W'(acc_alu) + CNT_W'(acc_br) + CNT_W'(acc_lsu);
        deq      = (count_q != '0);
        slot_br  = wr_ptr_q + PTR_W'(acc_alu);
        slot_lsu = slot_br + PTR_W'(acc_br);
        wr_ptr_d = wr_ptr_q + n_enq[PTR_W-1:0];
        rd_ptr_d = rd_ptr_q + PTR_W'(deq);
        count_d  = count_q + n_enq - CNT_W'(deq);
    end

    always_ff @(posedge clk) begin
        if (acc_alu) cq_mem_q[wr_ptr_q] <= alu_wb_rob;
        if (acc_br)  cq_mem_q[slot_br]  <= br_wb_rob;
        if (acc_lsu) cq_mem_q[slot_lsu] <= lsu_wb_rob;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            complete_q <= 1'b0;
            rob_tag_q  <= '0;
            pv1_q      <= 1'b0;
            pv2_q      <= 1'b0;
            pv3_q      <= 1'b0;
            preg1_q    <= '0;
            preg2_q    <= '0;
            preg3_q    <= '0;
        end else if (mispredict) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            complete_q <= 1'b0;
            pv1_q      <= 1'b0;
            pv2_q      <= 1'b0;
            pv3_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            complete_q <= deq;
            if (deq) rob_tag_q <= cq_mem_q[rd_ptr_q];
            pv1_q <= bc_alu;
            pv2_q <= bc_br;
            pv3_q <= bc_lsu;
            if (bc_alu) preg1_q <= alu_wb_prd;
            if (bc_br)  preg2_q <= br_wb_prd;
            if (bc_lsu) preg3_q <= lsu_wb_prd;
        end
    end

    assign alu_wb_ready = ready;
    assign br_wb_ready  = ready;
    assign lsu_wb_ready = ready;
    assign preg1_rdy    = preg1_q;
    assign preg1_valid  = pv1_q;
    assign preg2_rdy    = preg2_q;
    assign preg2_valid  = pv2_q;
    assign preg3_rdy    = preg3_q;
    assign preg3_valid  = pv3_q;
    assign complete_out = complete_q;
    assign rob_fu_tag   = rob_tag_q;
endmodule

// File: tb/tb_writeback_cdb.sv
// Directed bench for writeback_cdb: broadcast latency, completion ordering,
// backpressure with wrap-around, flush, reset and the count==5 boundary.
module tb_writeback_cdb;
    logic       clk = 1'b0;
    logic       reset, mispredict;
    logic       alu_wb_valid, alu_wb_we, alu_wb_ready;
    logic [6:0] alu_wb_prd;
    logic [4:0] alu_wb_rob;
    logic       br_wb_valid, br_wb_we, br_wb_ready;
    logic [6:0] br_wb_prd;
    logic [4:0] br_wb_rob;
    logic       lsu_wb_valid, lsu_wb_we, lsu_wb_ready;
    logic [6:0] lsu_wb_prd;
    logic [4:0] lsu_wb_rob;
    logic [6:0] preg1_rdy, preg2_rdy, preg3_rdy;
    logic       preg1_valid, preg2_valid, preg3_valid;
    logic       complete_out;
    logic [4:0] rob_fu_tag;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_cdb #(.PREG_W(7), .ROB_W(5), .CQ_DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .alu_wb_valid(alu_wb_valid), .alu_wb_prd(alu_wb_prd), .alu_wb_we(alu_wb_we),
        .alu_wb_rob(alu_wb_rob), .alu_wb_ready(alu_wb_ready),
        .br_wb_valid(br_wb_valid), .br_wb_prd(br_wb_prd), .br_wb_we(br_wb_we),
        .br_wb_rob(br_wb_rob), .br_wb_ready(br_wb_ready),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_prd(lsu_wb_prd), .lsu_wb_we(lsu_wb_we),
        .lsu_wb_rob(lsu_wb_rob), .lsu_wb_ready(lsu_wb_ready),
        .mispredict(mispredict),
        .preg1_rdy(preg1_rdy), .preg1_valid(preg1_valid),
        .preg2_rdy(preg2_rdy), .preg2_valid(preg2_valid),
        .preg3_rdy(preg3_rdy), .preg3_valid(preg3_valid),
        .complete_out(complete_out), .rob_fu_tag(rob_fu_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_alu(input logic v, input logic [6:0] prd, input logic we, input logic [4:0] rob);
        alu_wb_valid = v; alu_wb_prd = prd; alu_wb_we = we; alu_wb_rob = rob;
    endtask

    task automatic drv_br(input logic v, input logic [6:0] prd, input logic we, input logic [4:0] rob);
        br_wb_valid = v; br_wb_prd = prd; br_wb_we = we; br_wb_rob = rob;
    endtask

    task automatic drv_lsu(input logic v, input logic [6:0] prd, input logic we, input logic [4:0] rob);
        lsu_wb_valid = v; lsu_wb_prd = prd; lsu_wb_we = we; lsu_wb_rob = rob;
    endtask

    task automatic idle();
        drv_alu(0, 0, 0, 0); drv_br(0, 0, 0, 0); drv_lsu(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b0; mispredict = 1'b0; idle();
        tick(); tick();
        n_checks++;
        if ({complete_out, rob_fu_tag, preg1_valid, preg2_valid, preg3_valid} !== 9'd0) begin
            n_fail++; $display("FAIL reset_outs: complete=%0b tag=%0d pv=%0b%0b%0b required all 0",
                               complete_out, rob_fu_tag, preg1_valid, preg2_valid, preg3_valid);
        end
        n_checks++;
        if ({preg1_rdy, preg2_rdy, preg3_rdy} !== 21'd0) begin
            n_fail++; $display("FAIL reset_rdy: %0d %0d %0d required 0 0 0", preg1_rdy, preg2_rdy, preg3_rdy);
        end
        n_checks++;
        if ({alu_wb_ready, br_wb_ready, lsu_wb_ready} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready: %b required 000", {alu_wb_ready, br_wb_ready, lsu_wb_ready});
        end
        reset = 1'b1; #1;
        n_checks++;
        if ({alu_wb_ready, br_wb_ready, lsu_wb_ready} !== 3'b111) begin
            n_fail++; $display("FAIL release_ready: %b required 111", {alu_wb_ready, br_wb_ready, lsu_wb_ready});
        end
    endtask

    task automatic test_single();
        drv_alu(1, 7'd12, 1, 5'd3);
        tick(); idle();
        n_checks++;
        if (preg1_valid !== 1'b1 || preg1_rdy !== 7'd12 || complete_out !== 1'b0) begin
            n_fail++; $display("FAIL single_t1: pv1=%0b rdy=%0d complete=%0b required 1 12 0",
                               preg1_valid, preg1_rdy, complete_out);
        end
        tick();
        n_checks++;
        if (preg1_valid !== 1'b0 || preg1_rdy !== 7'd12 || complete_out !== 1'b1 || rob_fu_tag !== 5'd3) begin
            n_fail++; $display("FAIL single_t2: pv1=%0b rdy=%0d complete=%0b tag=%0d required 0 12 1 3",
                               preg1_valid, preg1_rdy, complete_out, rob_fu_tag);
        end
        tick();
        n_checks++;
        if (complete_out !== 1'b0 || rob_fu_tag !== 5'd3) begin
            n_fail++; $display("FAIL single_t3: complete=%0b tag=%0d required 0 3", complete_out, rob_fu_tag);
        end
    endtask

    task automatic test_triple();
        logic [4:0] exp_tags [3];
        exp_tags[0] = 5'd1; exp_tags[1] = 5'd2; exp_tags[2] = 5'd4;
        drv_alu(1, 7'd5, 1, 5'd1);
        drv_br(1, 7'd9, 0, 5'd2);
        drv_lsu(1, 7'd0, 1, 5'd4);
        tick(); idle();
        n_checks++;
        if ({preg1_valid, preg2_valid, preg3_valid} !== 3'b100 || preg1_rdy !== 7'd5
            || preg2_rdy !== 7'd0 || preg3_rdy !== 7'd0 || complete_out !== 1'b0) begin
            n_fail++; $display("FAIL triple_bcast: pv=%b rdy=%0d/%0d/%0d complete=%0b required 100 5/0/0 0",
                               {preg1_valid, preg2_valid, preg3_valid}, preg1_rdy, preg2_rdy, preg3_rdy, complete_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (complete_out !== 1'b1 || rob_fu_tag !== exp_tags[i]) begin
                n_fail++; $display("FAIL triple_cmpl%0d: complete=%0b tag=%0d required 1 %0d",
                                   i, complete_out, rob_fu_tag, exp_tags[i]);
            end
        end
        tick();
        n_checks++;
        if (complete_out !== 1'b0) begin
            n_fail++; $display("FAIL triple_end: complete=%0b required 0", complete_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_q [$];
        int   sent, got, cm, n;
        logic prev_acc, low_seen, rdy;
        sent = 0; got = 0; cm = 0; prev_acc = 1'b0; low_seen = 1'b0;
        for (int cyc = 0; cyc < 200 && got < 24; cyc++) begin
            if (complete_out === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra: unexpected completion tag=%0d", rob_fu_tag);
                end else begin
                    if (rob_fu_tag !== exp_q[0]) begin
                        n_fail++; $display("FAIL bp_order: tag=%0d required %0d", rob_fu_tag, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            n_checks++;
            if (preg1_valid !== prev_acc) begin
                n_fail++; $display("FAIL bp_bcast: pv1=%0b required %0b", preg1_valid, prev_acc);
            end
            rdy = (cm <= 5);
            n_checks++;
            if (alu_wb_ready !== rdy || br_wb_ready !== rdy || lsu_wb_ready !== rdy) begin
                n_fail++; $display("FAIL bp_ready: %b required all %0b",
                                   {alu_wb_ready, br_wb_ready, lsu_wb_ready}, rdy);
            end
            if (!rdy) low_seen = 1'b1;
            idle();
            n = 0;
            if (sent < 24) begin drv_alu(1, 7'(sent + 1), 1, 5'(sent)); n++; end
            if (sent + 1 < 24) begin drv_br(1, 7'(sent + 2), 1, 5'(sent + 1)); n++; end
            if (sent + 2 < 24) begin drv_lsu(1, 7'(sent + 3), 1, 5'(sent + 2)); n++; end
            prev_acc = rdy && (sent < 24);
            if (!rdy) n = 0;
            for (int k = 0; k < n; k++) exp_q.push_back(5'(sent + k));
            sent += n;
            cm = cm + n - ((cm != 0) ? 1 : 0);
            tick();
        end
        idle();
        n_checks++;
        if (got !== 24 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL bp_total: completed %0d, %0d left, required 24 and 0", got, exp_q.size());
        end
        n_checks++;
        if (low_seen !== 1'b1) begin
            n_fail++; $display("FAIL bp_backpressure: ready never dropped, required a drop");
        end
        tick(); tick();
    endtask

    task automatic test_flush();
        drv_alu(1, 7'd40, 1, 5'd10); drv_br(1, 7'd41, 1, 5'd11); drv_lsu(1, 7'd42, 1, 5'd12);
        tick(); idle();
        drv_alu(1, 7'd43, 1, 5'd13);
        tick(); idle();
        n_checks++;
        if (complete_out !== 1'b1 || rob_fu_tag !== 5'd10) begin
            n_fail++; $display("FAIL flush_pre: complete=%0b tag=%0d required 1 10", complete_out, rob_fu_tag);
        end
        mispredict = 1'b1; #1;
        n_checks++;
        if ({alu_wb_ready, br_wb_ready, lsu_wb_ready} !== 3'b000) begin
            n_fail++; $display("FAIL flush_ready: %b required 000", {alu_wb_ready, br_wb_ready, lsu_wb_ready});
        end
        tick();
        mispredict = 1'b0; #1;
        n_checks++;
        if (complete_out !== 1'b0 || preg1_valid !== 1'b0 || {alu_wb_ready, br_wb_ready, lsu_wb_ready} !== 3'b111) begin
            n_fail++; $display("FAIL flush_post: complete=%0b pv1=%0b ready=%b required 0 0 111",
                               complete_out, preg1_valid, {alu_wb_ready, br_wb_ready, lsu_wb_ready});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (complete_out !== 1'b0) begin
                n_fail++; $display("FAIL flush_stale%0d: complete=%0b tag=%0d required 0", i, complete_out, rob_fu_tag);
            end
        end
        drv_alu(1, 7'd20, 1, 5'd7);
        tick(); idle();
        n_checks++;
        if (preg1_valid !== 1'b1 || preg1_rdy !== 7'd20 || complete_out !== 1'b0) begin
            n_fail++; $display("FAIL flush_new_t1: pv1=%0b rdy=%0d complete=%0b required 1 20 0",
                               preg1_valid, preg1_rdy, complete_out);
        end
        tick();
        n_checks++;
        if (complete_out !== 1'b1 || rob_fu_tag !== 5'd7) begin
            n_fail++; $display("FAIL flush_new_t2: complete=%0b tag=%0d required 1 7", complete_out, rob_fu_tag);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drv_alu(1, 7'd30, 1, 5'd1); drv_br(1, 7'd31, 1, 5'd2); drv_lsu(1, 7'd32, 1, 5'd3);
        tick(); idle();
        n_checks++;
        if ({preg1_valid, preg2_valid, preg3_valid} !== 3'b111) begin
            n_fail++; $display("FAIL rstmid_pre: pv=%b required 111", {preg1_valid, preg2_valid, preg3_valid});
        end
        reset = 1'b0; #1;
        n_checks++;
        if ({alu_wb_ready, br_wb_ready, lsu_wb_ready} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_ready: %b required 000", {alu_wb_ready, br_wb_ready, lsu_wb_ready});
        end
        tick();
        n_checks++;
        if ({complete_out, rob_fu_tag, preg1_valid, preg2_valid, preg3_valid} !== 9'd0
            || {preg1_rdy, preg2_rdy, preg3_rdy} !== 21'd0) begin
            n_fail++; $display("FAIL rstmid_outs: complete=%0b tag=%0d pv=%b rdy=%0d/%0d/%0d required all 0",
                               complete_out, rob_fu_tag, {preg1_valid, preg2_valid, preg3_valid},
                               preg1_rdy, preg2_rdy, preg3_rdy);
        end
        reset = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (complete_out !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_stale%0d: complete=%0b tag=%0d required 0", i, complete_out, rob_fu_tag);
            end
        end
    endtask

    task automatic test_boundary();
        logic [4:0] exp_tags [7];
        int bi;
        bi = 0;
        for (int i = 0; i < 7; i++) exp_tags[i] = 5'(21 + i);
        for (int c = 0; c < 12; c++) begin
            if (complete_out === 1'b1) begin
                n_checks++;
                if (bi >= 7 || rob_fu_tag !== exp_tags[(bi < 7) ? bi : 0]) begin
                    n_fail++; $display("FAIL bnd_order: tag=%0d index %0d", rob_fu_tag, bi);
                end
                bi++;
            end
            if (c >= 1 && c <= 3) begin
                n_checks++;
                if ({alu_wb_ready, br_wb_ready, lsu_wb_ready} !== 3'b111) begin
                    n_fail++; $display("FAIL bnd_ready_c%0d: %b required 111", c,
                                       {alu_wb_ready, br_wb_ready, lsu_wb_ready});
                end
            end
            idle();
            case (c)
                0: begin drv_alu(1, 7'd0, 0, 5'd21); drv_br(1, 7'd0, 0, 5'd22); drv_lsu(1, 7'd0, 0, 5'd23); end
                1: begin drv_alu(1, 7'd0, 0, 5'd24); drv_br(1, 7'd0, 0, 5'd25); drv_lsu(1, 7'd0, 0, 5'd26); end
                2: drv_alu(1, 7'd0, 0, 5'd27);
                default: ;
            endcase
            tick();
        end
        idle();
        n_checks++;
        if (bi !== 7) begin
            n_fail++; $display("FAIL bnd_total: %0d completions required 7", bi);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_triple();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
